perf_counter_bank: RTL and testbench
====================================

Name: perf_counter_bank

Overview:
- Parametrised multi-channel cycle/event counter bank for FPGA bring-up and performance debug.
- Successor to the single free-running cycle counter. Adds per-channel width-generic counters, per-channel cycle/event mode, global enable, per-channel clear, wrap or saturate policy, and sticky overflow.
- Adds an atomic snapshot of all channels, delivered over a valid/ready handshake.
- Instantiated beside the SoC on the FPGA target; all counter state is kept for ILA probing.

Parameters:
- NumCnt, 4, number of counter channels (>=1).
- CntWidth, 64, bits per counter (>=2).
- Saturate, 1'b0, 0 = wrap to zero on overflow; 1 = hold at all-ones.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- en_i  in  1  global count enable.
- mode_i  in  NumCnt  per channel: 0 = CYCLE (count every enabled cycle), 1 = EVENT (count when event_i[k]=1).
- event_i  in  NumCnt  per-channel event strobe, one increment per cycle high.
- clear_i  in  NumCnt  per-channel synchronous clear of counter and overflow flag.
- count_o  out  NumCnt*CntWidth  live counter values; channel k at [k*CntWidth +: CntWidth].
- overflow_o  out  NumCnt  sticky overflow flags.
- snap_req_i  in  1  request atomic snapshot.
- snap_valid_o  out  1  snapshot data valid.
- snap_ready_i  in  1  consumer accepts snapshot.
- snap_data_o  out  NumCnt*CntWidth  captured counter values.
- snap_ovf_o  out  NumCnt  captured overflow flags.
- snap_drop_o  out  1  one-cycle pulse: request ignored because a snapshot is pending.

Behaviour:
- Reset (rst_i=1 at a clock edge): all counters, overflow_o, snap_valid_o, snap_data_o, snap_ovf_o and snap_drop_o go to 0. Reset overrides every other input.
- Increment condition for channel k: inc_k = en_i & (mode_i[k] ? event_i[k] : 1).
- Update takes effect at the next edge; count_o is registered and has 1-cycle latency from inc_k.
- Priority per channel: rst_i > clear_i[k] > increment.
  - Clear together with an increment yields 0, not 1.
  - Clear also resets overflow_o[k].
- Overflow, triggered by inc_k while the count is all-ones:
  - Saturate=0: count wraps to 0 and overflow_o[k] is set.
  - Saturate=1: count stays all-ones and overflow_o[k] is set.
  - The flag stays set until clear_i[k] or reset.
- mode_i and en_i are sampled every cycle. Changing mode mid-count does not alter the current value.
- Snapshot handshake, two states IDLE and HOLD:
  - IDLE & snap_req_i: capture the current registered count_o/overflow_o (the pre-update values of that same edge) into snap_data_o/snap_ovf_o. Go to HOLD with snap_valid_o=1 on the next cycle.
  - HOLD: snap_data_o/snap_ovf_o are stable. snap_valid_o stays 1 until snap_valid_o & snap_ready_i, then return to IDLE.
  - HOLD & snap_req_i, with no handshake completing that cycle: the request is dropped and snap_drop_o pulses 1 for that cycle.
  - HOLD & handshake & snap_req_i in the same cycle: the new capture is taken and the block stays in HOLD (back-to-back snapshots); no drop.
  - Snapshot captured in the same cycle as clear_i[k]: the snapshot holds the pre-clear value.
  - Counters keep running during HOLD.
  - Reset in HOLD: go to IDLE with snap_valid_o=0; the pending snapshot is discarded.
- No combinational path from any input to any output.

Decomposition:
- Package perf_counter_pkg:
  - cnt_mode_e enum {CntCycle=1'b0, CntEvent=1'b1}.
  - snap_state_e enum {SnapIdle, SnapHold}.
  - Default-width constants.
- Sub-module perf_counter_chan: one channel holding the counter, overflow flag, clear priority and wrap/saturate logic. Its parameters are CntWidth and Saturate.
- Top-level perf_counter_bank: generate loop over channels plus the snapshot FSM.

Test Plan:
- Reset, then en_i=1 with all channels in CYCLE mode for 10 cycles -> every count_o = 10, overflow_o = 0.
- CntWidth=4, Saturate=0, EVENT mode, 17 event pulses -> count = 1, overflow_o[k] = 1. Then clear_i[k] together with an event -> count = 0, overflow = 0.
- CntWidth=4, Saturate=1, 20 event pulses -> count = 15, overflow = 1. Further events keep the count at 15.
- Counters at {5,7,9,11}: snap_req_i for one cycle with snap_ready_i=0 for 5 cycles -> snap_data_o = {5,7,9,11}, stable while counters advance. A second snap_req_i in that window -> snap_drop_o pulse. Raise snap_ready_i -> snap_valid_o falls on the next cycle.
- Back-to-back: handshake and a new snap_req_i in the same cycle -> snap_valid_o stays 1 with updated data, no drop. A reset asserted while in HOLD -> snap_valid_o = 0 and all counts = 0 on the next cycle.
- en_i=0 with events active -> no count changes. Mode toggled from CYCLE to EVENT at count 3 with no events -> count holds at 3.

Source files
------------

// File: rtl/perf_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : perf_counter_pkg
//  Description : Shared types and default sizes for the performance counter
//                bank (channel mode, snapshot state, default widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package perf_counter_pkg;

  // Per-channel counting mode, selected by one bit of mode_i.
  typedef enum logic [0:0] {
    CntCycle = 1'b0,  // count every enabled cycle
    CntEvent = 1'b1   // count only cycles where the channel event strobe is high
  } cnt_mode_e;

  // Snapshot handshake state.
  typedef enum logic [0:0] {
    SnapIdle = 1'b0,
    SnapHold = 1'b1
  } snap_state_e;

  localparam int unsigned c_def_num_cnt   = 4;
  localparam int unsigned c_def_cnt_width = 64;
  localparam logic        c_def_saturate  = 1'b0;

endpackage : perf_counter_pkg
`default_nettype wire

// File: rtl/perf_counter_chan.sv
`default_nettype none
// ============================================================================
//  Module      : perf_counter_chan
//  Description : One counter channel: increment qualification, clear,
//                wrap/saturate on overflow and a sticky overflow flag.
//  Ports       : clk_i, rst_i     - clock, synchronous active-high reset
//                en_i             - global count enable
//                mode_i           - 0 = cycle mode, 1 = event mode
//                event_i          - event strobe (used in event mode)
//                clear_i          - clears counter and overflow flag
//                count_o          - registered counter value
//                overflow_o       - sticky overflow flag
//  Revision    : 1.0 - initial release
// ============================================================================
module perf_counter_chan
  import perf_counter_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = c_def_cnt_width,
  parameter logic        SATURATE  = c_def_saturate
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 mode_i,
  input  logic                 event_i,
  input  logic                 clear_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 overflow_o
);

  localparam logic [CNT_WIDTH-1:0] c_one = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_ovf;
  logic                 w_inc;
  logic                 w_at_max;

  assign w_inc    = en_i & ((cnt_mode_e'(mode_i) == CntEvent) ? event_i : 1'b1);
  assign w_at_max = &r_count;

  // Clear beats increment, so a clear coinciding with an event lands on 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (clear_i) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_inc) begin
      if (w_at_max) begin
        r_ovf <= 1'b1;
        // Saturating channels simply keep the all-ones value.
        if (!SATURATE) begin
          r_count <= '0;
        end
      end else begin
        r_count <= r_count + c_one;
      end
    end
  end

  assign count_o    = r_count;
  assign overflow_o = r_ovf;

endmodule : perf_counter_chan
`default_nettype wire

// File: rtl/perf_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : perf_counter_bank
//  Description : Multi-channel cycle/event counter bank with an atomic
//                snapshot of all channels delivered over valid/ready.
//  Ports       : clk_i, rst_i     - clock, synchronous active-high reset
//                en_i             - global count enable
//                mode_i/event_i   - per-channel mode and event strobes
//                clear_i          - per-channel clear
//                count_o          - live counts, channel k at [k*W +: W]
//                overflow_o       - sticky per-channel overflow flags
//                snap_req_i       - snapshot request
//                snap_valid_o     - snapshot held and valid
//                snap_ready_i     - consumer accepts the snapshot
//                snap_data_o      - captured counts
//                snap_ovf_o       - captured overflow flags
//                snap_drop_o      - pulse: request ignored, snapshot pending
//  Revision    : 1.0 - initial release
// ============================================================================
module perf_counter_bank
  import perf_counter_pkg::*;
#(
  parameter int unsigned NUM_CNT   = c_def_num_cnt,
  parameter int unsigned CNT_WIDTH = c_def_cnt_width,
  parameter logic        SATURATE  = c_def_saturate
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  input  logic [NUM_CNT-1:0]             mode_i,
  input  logic [NUM_CNT-1:0]             event_i,
  input  logic [NUM_CNT-1:0]             clear_i,
  output logic [NUM_CNT*CNT_WIDTH-1:0]   count_o,
  output logic [NUM_CNT-1:0]             overflow_o,
  input  logic                           snap_req_i,
  output logic                           snap_valid_o,
  input  logic                           snap_ready_i,
  output logic [NUM_CNT*CNT_WIDTH-1:0]   snap_data_o,
  output logic [NUM_CNT-1:0]             snap_ovf_o,
  output logic                           snap_drop_o
);

  logic [NUM_CNT*CNT_WIDTH-1:0] w_count;
  logic [NUM_CNT-1:0]           w_ovf;

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_chan
    perf_counter_chan #(
      .CNT_WIDTH (CNT_WIDTH),
      .SATURATE  (SATURATE)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (en_i),
      .mode_i     (mode_i[k]),
      .event_i    (event_i[k]),
      .clear_i    (clear_i[k]),
      .count_o    (w_count[k*CNT_WIDTH +: CNT_WIDTH]),
      .overflow_o (w_ovf[k])
    );
  end

  assign count_o    = w_count;
  assign overflow_o = w_ovf;

  // Snapshot FSM
  snap_state_e                  r_state;
  snap_state_e                  w_state_nxt;
  logic                         w_capture;
  logic                         w_drop_nxt;
  logic                         w_handshake;
  logic [NUM_CNT*CNT_WIDTH-1:0] r_snap_data;
  logic [NUM_CNT-1:0]           r_snap_ovf;
  logic                         r_drop;

  assign w_handshake = (r_state == SnapHold) & snap_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_drop_nxt  = 1'b0;
    case (r_state)
      SnapIdle: begin
        if (snap_req_i) begin
          w_capture   = 1'b1;
          w_state_nxt = SnapHold;
        end
      end
      SnapHold: begin
        if (w_handshake) begin
          // A request arriving as the held snapshot is consumed is taken
          // immediately, giving back-to-back snapshots without a drop.
          if (snap_req_i) begin
            w_capture = 1'b1;
          end else begin
            w_state_nxt = SnapIdle;
          end
        end else if (snap_req_i) begin
          w_drop_nxt = 1'b1;
        end
      end
      default: w_state_nxt = SnapIdle;
    endcase
  end

  // Capture samples the registered counts, i.e. the values before this
  // edge's increment or clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= SnapIdle;
      r_snap_data <= '0;
      r_snap_ovf  <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
      if (w_capture) begin
        r_snap_data <= w_count;
        r_snap_ovf  <= w_ovf;
      end
    end
  end

  assign snap_valid_o = (r_state == SnapHold);
  assign snap_data_o  = r_snap_data;
  assign snap_ovf_o   = r_snap_ovf;
  assign snap_drop_o  = r_drop;

endmodule : perf_counter_bank
`default_nettype wire

// File: tb/tb_perf_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_perf_counter_bank
//  Description : Self-checking bench for perf_counter_bank. Three instances
//                share one stimulus: 64-bit wrap, 4-bit wrap, 4-bit saturate.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_counter_bank;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, snap_req, snap_ready;
  logic [N-1:0] mode, evt, clr;

  // instance 0: 64-bit wrap
  logic [N*64-1:0] cnt0, sd0;
  logic [N-1:0]    ovf0, so0;
  logic            valid0, drop0;
  // instance 1: 4-bit wrap
  logic [N*4-1:0]  cnt1, sd1;
  logic [N-1:0]    ovf1, so1;
  logic            valid1, drop1;
  // instance 2: 4-bit saturate
  logic [N*4-1:0]  cnt2, sd2;
  logic [N-1:0]    ovf2, so2;
  logic            valid2, drop2;

  perf_counter_bank #(.NUM_CNT(N), .CNT_WIDTH(64), .SATURATE(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .event_i(evt),
    .clear_i(clr), .count_o(cnt0), .overflow_o(ovf0), .snap_req_i(snap_req),
    .snap_valid_o(valid0), .snap_ready_i(snap_ready), .snap_data_o(sd0),
    .snap_ovf_o(so0), .snap_drop_o(drop0)
  );
  perf_counter_bank #(.NUM_CNT(N), .CNT_WIDTH(4), .SATURATE(1'b0)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .event_i(evt),
    .clear_i(clr), .count_o(cnt1), .overflow_o(ovf1), .snap_req_i(snap_req),
    .snap_valid_o(valid1), .snap_ready_i(snap_ready), .snap_data_o(sd1),
    .snap_ovf_o(so1), .snap_drop_o(drop1)
  );
  perf_counter_bank #(.NUM_CNT(N), .CNT_WIDTH(4), .SATURATE(1'b1)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .event_i(evt),
    .clear_i(clr), .count_o(cnt2), .overflow_o(ovf2), .snap_req_i(snap_req),
    .snap_valid_o(valid2), .snap_ready_i(snap_ready), .snap_data_o(sd2),
    .snap_ovf_o(so2), .snap_drop_o(drop2)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- DUT accessors ----------------
  function automatic logic [63:0] dcnt(input int d, input int k);
    case (d)
      0:       return cnt0[k*64 +: 64];
      1:       return {60'b0, cnt1[k*4 +: 4]};
      default: return {60'b0, cnt2[k*4 +: 4]};
    endcase
  endfunction
  function automatic logic [63:0] dsd(input int d, input int k);
    case (d)
      0:       return sd0[k*64 +: 64];
      1:       return {60'b0, sd1[k*4 +: 4]};
      default: return {60'b0, sd2[k*4 +: 4]};
    endcase
  endfunction
  function automatic logic dovf(input int d, input int k);
    return (d == 0) ? ovf0[k] : (d == 1) ? ovf1[k] : ovf2[k];
  endfunction
  function automatic logic dso(input int d, input int k);
    return (d == 0) ? so0[k] : (d == 1) ? so1[k] : so2[k];
  endfunction
  function automatic logic dvalid(input int d);
    return (d == 0) ? valid0 : (d == 1) ? valid1 : valid2;
  endfunction
  function automatic logic ddrop(input int d);
    return (d == 0) ? drop0 : (d == 1) ? drop1 : drop2;
  endfunction

  // ---------------- behavioural model ----------------
  logic [63:0] m_cnt [3][N];
  logic        m_ovf [3][N];
  logic [63:0] m_sd  [3][N];
  logic        m_so  [3][N];
  logic        m_pend[3];
  logic        m_drop[3];

  function automatic logic [63:0] maxv(input int d);
    return (d == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hF;
  endfunction

  // Counts are integers that roll at maxv (or stick there when saturating);
  // the snapshot is "pending or not", refilled when free or being consumed.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_pend[d] <= 1'b0;
        m_drop[d] <= 1'b0;
        for (int k = 0; k < N; k++) begin
          m_cnt[d][k] <= '0; m_ovf[d][k] <= 1'b0;
          m_sd[d][k]  <= '0; m_so[d][k]  <= 1'b0;
        end
      end else begin
        m_drop[d] <= m_pend[d] && snap_req && !snap_ready;
        if (snap_req && (!m_pend[d] || snap_ready)) begin
          m_pend[d] <= 1'b1;
          for (int k = 0; k < N; k++) begin
            m_sd[d][k] <= m_cnt[d][k];
            m_so[d][k] <= m_ovf[d][k];
          end
        end else if (m_pend[d] && snap_ready) begin
          m_pend[d] <= 1'b0;
        end
        for (int k = 0; k < N; k++) begin
          if (clr[k]) begin
            m_cnt[d][k] <= '0;
            m_ovf[d][k] <= 1'b0;
          end else if (en && (mode[k] ? evt[k] : 1'b1)) begin
            if (m_cnt[d][k] == maxv(d)) begin
              m_ovf[d][k] <= 1'b1;
              m_cnt[d][k] <= (d == 2) ? maxv(d) : 64'd0;
            end else begin
              m_cnt[d][k] <= m_cnt[d][k] + 64'd1;
            end
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("d%0d valid", d), {63'b0, dvalid(d)}, {63'b0, m_pend[d]});
        chk($sformatf("d%0d drop", d),  {63'b0, ddrop(d)},  {63'b0, m_drop[d]});
        for (int k = 0; k < N; k++) begin
          chk($sformatf("d%0d cnt%0d", d, k),  dcnt(d, k), m_cnt[d][k]);
          chk($sformatf("d%0d ovf%0d", d, k),  {63'b0, dovf(d, k)}, {63'b0, m_ovf[d][k]});
          chk($sformatf("d%0d sdat%0d", d, k), dsd(d, k), m_sd[d][k]);
          chk($sformatf("d%0d sovf%0d", d, k), {63'b0, dso(d, k)}, {63'b0, m_so[d][k]});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- directed stimulus + literal expectations ----------------
  initial begin
    int tgt [N];
    tgt = '{5, 7, 9, 11};
    rst = 1'b1; en = 1'b0; mode = '0; evt = '0; clr = '0;
    snap_req = 1'b0; snap_ready = 1'b0;
    tick(1);
    chk_on = 1'b1;
    tick(1);
    chk("rst cnt0", dcnt(0, 0), 64'd0);
    chk("rst valid", {63'b0, valid0}, 64'd0);
    chk("rst ovf", {60'b0, ovf0}, 64'd0);

    // Cycle mode, 10 enabled cycles
    rst = 1'b0; en = 1'b1; mode = 4'h0;
    tick(10);
    for (int k = 0; k < N; k++) chk($sformatf("cycle10 ch%0d", k), dcnt(0, k), 64'd10);
    chk("cycle10 ovf", {60'b0, ovf0}, 64'd0);
    chk("model cycle10", m_cnt[0][3], 64'd10);

    // Event mode overflow: 17 pulses
    rst = 1'b1; tick(1); rst = 1'b0;
    mode = 4'hF; evt = 4'hF;
    tick(17);
    chk("wrap17 cnt", dcnt(1, 0), 64'd1);
    chk("wrap17 ovf", {63'b0, ovf1[0]}, 64'd1);
    chk("sat17 cnt", dcnt(2, 0), 64'd15);
    chk("sat17 ovf", {63'b0, ovf2[0]}, 64'd1);
    chk("model wrap17", m_cnt[1][2], 64'd1);
    clr = 4'h1;                       // clear together with an event
    tick(1);
    clr = 4'h0;
    chk("clr cnt", dcnt(1, 0), 64'd0);
    chk("clr ovf", {63'b0, ovf1[0]}, 64'd0);
    chk("noclr cnt", dcnt(1, 1), 64'd2);
    chk("noclr ovf", {63'b0, ovf1[1]}, 64'd1);
    tick(3);                          // 21 pulses on saturating channel 1
    chk("sat21 cnt", dcnt(2, 1), 64'd15);
    chk("sat21 ovf", {63'b0, ovf2[1]}, 64'd1);
    chk("sat after clr", dcnt(2, 0), 64'd3);

    // Build counts {5,7,9,11}
    evt = 4'h0; rst = 1'b1; tick(1); rst = 1'b0;
    en = 1'b1; mode = 4'hF;
    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < N; k++) evt[k] = (i < tgt[k]);
      tick(1);
    end
    evt = 4'h0;
    for (int k = 0; k < N; k++) chk($sformatf("pre ch%0d", k), dcnt(0, k), 64'(tgt[k]));

    // Snapshot while counters keep running in cycle mode
    snap_req = 1'b1; mode = 4'h0;
    tick(1);
    snap_req = 1'b0;
    chk("snap valid", {63'b0, valid0}, 64'd1);
    for (int k = 0; k < N; k++) chk($sformatf("snap ch%0d", k), dsd(0, k), 64'(tgt[k]));
    chk("live advances", dcnt(0, 0), 64'd6);
    tick(2);
    snap_req = 1'b1;
    tick(1);
    snap_req = 1'b0;
    chk("drop pulse", {63'b0, drop0}, 64'd1);
    chk("snap stable", dsd(0, 3), 64'd11);
    tick(1);
    chk("drop end", {63'b0, drop0}, 64'd0);
    snap_ready = 1'b1;
    tick(1);
    snap_ready = 1'b0;
    chk("valid falls", {63'b0, valid0}, 64'd0);

    // Back-to-back snapshots, then reset while holding
    snap_req = 1'b1;
    tick(1);
    chk("b2b first", {63'b0, valid0}, 64'd1);
    snap_ready = 1'b1;
    tick(1);
    snap_req = 1'b0; snap_ready = 1'b0;
    chk("b2b valid", {63'b0, valid0}, 64'd1);
    chk("b2b nodrop", {63'b0, drop0}, 64'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst hold valid", {63'b0, valid0}, 64'd0);
    for (int k = 0; k < N; k++) chk($sformatf("rst hold ch%0d", k), dcnt(0, k), 64'd0);

    // Enable off with events active, then mode switch at count 3
    en = 1'b0; mode = 4'hF; evt = 4'hF;
    tick(4);
    chk("en0 cnt", dcnt(0, 2), 64'd0);
    en = 1'b1; mode = 4'h0; evt = 4'h0;
    tick(3);
    chk("cyc3", dcnt(0, 0), 64'd3);
    mode = 4'hF;
    tick(3);
    chk("mode hold", dcnt(0, 0), 64'd3);
    chk("mode hold model", m_cnt[0][0], 64'd3);

    tick(1);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_perf_counter_bank
`default_nettype wire
